// File: rtl/mem_access_unit_pkg.sv
// Shared processor package: MEM-stage FSM states, byte-enable constants, bus widths.
package mem_access_unit_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned BE_W            = 4;
  localparam int unsigned RD_W            = 5;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  localparam logic [BE_W-1:0] BE_WORD  = 4'b1111;
  localparam logic [BE_W-1:0] BE_BYTE0 = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_e;

  // Memory op captured from EX/MEM when the unit starts a transaction.
  typedef struct packed {
    logic            err;
    logic            store;
    logic            regwrite;
    logic            lh;
    logic            ld;
    logic            halt;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] addr;
  } mem_op_t;

  function automatic logic [BE_W-1:0] byte_lane(input logic [1:0] addr_lo);
    return BE_W'(BE_BYTE0 << addr_lo);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load data alignment and sign extension for byte, halfword and word loads.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic            lh,
  input  logic            ld,
  output logic [XLEN-1:0] data_c
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    if (lh)      data_c = {{16{half[15]}}, half};
    else if (ld) data_c = {{24{byte_sel[7]}}, byte_sel};
    else         data_c = rdata;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: single-outstanding bus access with stall, alignment check and MEM/WB register.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            regWrite,
  input  logic            memtoReg,
  input  logic            memWrite,
  input  logic            sb,
  input  logic            lh,
  input  logic            ld,
  input  logic [31:0]     ALUresult,
  input  logic [31:0]     readData2,
  input  logic [4:0]      rd,
  input  logic            halt,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            wb_regWrite,
  output logic [4:0]      wb_rd,
  output logic [31:0]     wb_data,
  output logic            wb_halt,
  output logic            misaligned
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  mau_state_e      state, state_nxt;
  mem_op_t         op_q, op_in;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] load_data;
  logic            mem_op;
  logic            misalign_in;
  logic            timeout;

  assign mem_op = memWrite | memtoReg;

  // Stores take priority over loads when both controls are set.
  always_comb begin
    if (memWrite)  misalign_in = !sb && (ALUresult[1:0] != 2'b00);
    else if (lh)   misalign_in = ALUresult[0];
    else           misalign_in = !ld && (ALUresult[1:0] != 2'b00);
    op_in          = '0;
    op_in.err      = misalign_in;
    op_in.store    = memWrite;
    op_in.regwrite = regWrite;
    op_in.lh       = lh & ~memWrite;
    op_in.ld       = ld & ~memWrite;
    op_in.halt     = halt;
    op_in.rd       = rd;
    op_in.addr     = ALUresult;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset)              wait_cnt <= '0;
    else if (state == BUSY) wait_cnt <= wait_cnt + CNT_W'(1);
    else                    wait_cnt <= '0;
  end

  assign timeout = (state == BUSY) && !mem_ack &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  load_extend u_load_extend (
    .rdata   (rdata_q),
    .addr_lo (op_q.addr[1:0]),
    .lh      (op_q.lh),
    .ld      (op_q.ld),
    .data_c  (load_data)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = mem_op;
        if (mem_op) state_nxt = misalign_in ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request, op capture and MEM/WB register; a bubble is written while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q        <= '0;
      rdata_q     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      wb_regWrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_halt     <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      misaligned  <= 1'b0;
      wb_regWrite <= 1'b0;
      wb_halt     <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_op) begin
            wb_regWrite <= regWrite;
            wb_rd       <= rd;
            wb_data     <= ALUresult;
            wb_halt     <= halt;
          end else begin
            op_q <= op_in;
            if (misalign_in) begin
              misaligned <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= memWrite;
              mem_addr  <= {ALUresult[31:2], 2'b00};
              mem_wdata <= !memWrite ? '0 :
                           sb ? {4{readData2[7:0]}} : readData2;
              mem_be    <= (memWrite && sb) ? byte_lane(ALUresult[1:0]) : BE_WORD;
            end
          end
        end
        BUSY: begin
          if (mem_ack || timeout) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
          end
          if (mem_ack) begin
            rdata_q <= mem_rdata;
          end else if (timeout) begin
            op_q.err   <= 1'b1;
            misaligned <= 1'b1;
          end
        end
        DONE: begin
          wb_regWrite <= op_q.regwrite & ~op_q.store & ~op_q.err;
          wb_rd       <= op_q.rd;
          wb_halt     <= op_q.halt;
          wb_data     <= op_q.err   ? '0 :
                         op_q.store ? op_q.addr : load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus reset, stray-ack and bus-wait sequences.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        regWrite, memtoReg, memWrite, sb, lh, ld, halt;
  logic [31:0] ALUresult, readData2;
  logic [4:0]  rd;
  logic        stall, mem_req, mem_we, mem_ack, misaligned;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [3:0]  mem_be;
  logic        wb_regWrite, wb_halt;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  always #5 clock = ~clock;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .regWrite(regWrite), .memtoReg(memtoReg), .memWrite(memWrite),
    .sb(sb), .lh(lh), .ld(ld),
    .ALUresult(ALUresult), .readData2(readData2), .rd(rd), .halt(halt),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data), .wb_halt(wb_halt),
    .misaligned(misaligned)
  );

  typedef struct {
    string       name;
    logic        mw, mr, rw, sb, lh, ld, halt;
    logic [31:0] alu, rd2, rdata;
    logic [4:0]  rd;
    int          ack_at;
    logic        e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_chk_wdata;
    logic        e_rw;
    logic [31:0] e_data;
    logic        e_chk_data;
  } vec_t;

  typedef struct {
    string       name;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        halt;
    logic        chk_data;
  } wb_t;

  wb_t  sb_q[$];
  vec_t vecs[14];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_nop();
    regWrite = 1'b0; memtoReg = 1'b0; memWrite = 1'b0;
    sb = 1'b0; lh = 1'b0; ld = 1'b0; halt = 1'b0;
    ALUresult = '0; readData2 = '0; rd = '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_wb();
    wb_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({e.name, "_wb_regWrite"}, 32'(wb_regWrite), 32'(e.rw));
      chk({e.name, "_wb_rd"}, 32'(wb_rd), 32'(e.rd));
      chk({e.name, "_wb_halt"}, 32'(wb_halt), 32'(e.halt));
      if (e.chk_data) chk({e.name, "_wb_data"}, wb_data, e.data);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_stall"}, 32'(stall), 32'd0);
    chk({nm, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({nm, "_bus"}, 32'({mem_we, mem_be}), 32'd0);
    chk({nm, "_mem_addr"}, mem_addr, 32'd0);
    chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({nm, "_wb_flags"}, 32'({wb_regWrite, wb_halt, misaligned}), 32'd0);
    chk({nm, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({nm, "_wb_data"}, wb_data, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    wb_t e;
    int  busy, stalls, edges;
    logic [31:0] exp_addr;
    regWrite = v.rw; memtoReg = v.mr; memWrite = v.mw;
    sb = v.sb; lh = v.lh; ld = v.ld; halt = v.halt;
    ALUresult = v.alu; readData2 = v.rd2; rd = v.rd;
    e = '{v.name, v.e_rw, v.rd, v.e_data, v.halt, v.e_chk_data};
    sb_q.push_back(e);
    exp_addr = v.alu & 32'hFFFF_FFFC;
    #1;
    chk({v.name, "_stall_issue"}, 32'(stall), 32'(v.mw | v.mr));
    if (!(v.mw | v.mr)) begin
      tick();
      drive_nop();
      check_wb();
      return;
    end
    stalls = 1;
    tick();
    edges = 1;
    if (v.e_mis) begin
      chk({v.name, "_mis_pulse"}, 32'(misaligned), 32'd1);
      chk({v.name, "_mis_no_req"}, 32'(mem_req), 32'd0);
      chk({v.name, "_mis_stall"}, 32'(stall), 32'd0);
      drive_nop();
      tick();
      chk({v.name, "_mis_end"}, 32'(misaligned), 32'd0);
      check_wb();
      return;
    end
    chk({v.name, "_req"}, 32'(mem_req), 32'd1);
    chk({v.name, "_we"}, 32'(mem_we), 32'(v.mw));
    chk({v.name, "_addr"}, mem_addr, exp_addr);
    chk({v.name, "_be"}, 32'(mem_be), 32'(v.e_be));
    if (v.e_chk_wdata) chk({v.name, "_wdata"}, mem_wdata, v.e_wdata);
    busy = 0;
    while (stall && busy < 40) begin
      busy++;
      stalls++;
      if (busy == v.ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
      end
      tick();
      edges++;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (stall) begin
        chk({v.name, "_hold_req"}, 32'(mem_req), 32'd1);
        chk({v.name, "_hold_addr"}, mem_addr, exp_addr);
      end
    end
    chk({v.name, "_stall_cycles"}, 32'(stalls), 32'(v.ack_at + 1));
    chk({v.name, "_req_drop"}, 32'(mem_req), 32'd0);
    chk({v.name, "_no_mis"}, 32'(misaligned), 32'd0);
    drive_nop();
    tick();
    edges++;
    chk({v.name, "_latency_edges"}, 32'(edges), 32'(v.ack_at + 2));
    check_wb();
  endtask

  initial begin
    vec_t v;
    wb_t  e;
    int   busy;

    //          name         mw mr rw sb lh ld halt alu            rd2            rdata          rd     ack mis be       wdata          chkw rw data           chkd
    vecs[0]  = '{"nonmem55",  N, N, Y, N, N, N, N, 32'h0000_0055, 32'h0,         32'h0,         5'd7,  0, N, 4'h0,   32'h0,         N,   Y, 32'h0000_0055, Y};
    vecs[1]  = '{"lh_102",    N, Y, Y, N, Y, N, N, 32'h0000_0102, 32'h0,         32'h8001_1234, 5'd9,  2, N, 4'hF,   32'h0,         N,   Y, 32'hFFFF_8001, Y};
    vecs[2]  = '{"sb_203",    Y, N, N, Y, N, N, N, 32'h0000_0203, 32'h0000_00AB, 32'h0,         5'd0,  1, N, 4'b1000, 32'hABAB_ABAB, Y,  N, 32'h0,         N};
    vecs[3]  = '{"lw_mis_6",  N, Y, Y, N, N, N, N, 32'h0000_0006, 32'h0,         32'h0,         5'd4,  1, Y, 4'h0,   32'h0,         N,   N, 32'h0,         Y};
    vecs[4]  = '{"lw_1000",   N, Y, Y, N, N, N, N, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 5'd3,  1, N, 4'hF,   32'h0,         N,   Y, 32'hDEAD_BEEF, Y};
    vecs[5]  = '{"lb_101",    N, Y, Y, N, N, Y, N, 32'h0000_0101, 32'h0,         32'h1122_8344, 5'd5,  1, N, 4'hF,   32'h0,         N,   Y, 32'hFFFF_FF83, Y};
    vecs[6]  = '{"lb_103",    N, Y, Y, N, N, Y, N, 32'h0000_0103, 32'h0,         32'h7F00_0000, 5'd6,  3, N, 4'hF,   32'h0,         N,   Y, 32'h0000_007F, Y};
    vecs[7]  = '{"lh_100",    N, Y, Y, N, Y, N, N, 32'h0000_0100, 32'h0,         32'hFFFF_7FFE, 5'd8,  1, N, 4'hF,   32'h0,         N,   Y, 32'h0000_7FFE, Y};
    vecs[8]  = '{"lh_mis_101", N, Y, Y, N, Y, N, N, 32'h0000_0101, 32'h0,        32'h0,         5'd10, 1, Y, 4'h0,   32'h0,         N,   N, 32'h0,         Y};
    vecs[9]  = '{"sw_40",     Y, N, Y, N, N, N, N, 32'h0000_0040, 32'h1234_5678, 32'h0,         5'd11, 3, N, 4'hF,   32'h1234_5678, Y,   N, 32'h0,         N};
    vecs[10] = '{"sb_200",    Y, N, N, Y, N, N, N, 32'h0000_0200, 32'h0000_01CD, 32'h0,         5'd0,  1, N, 4'b0001, 32'hCDCD_CDCD, Y,  N, 32'h0,         N};
    vecs[11] = '{"st_prio",   Y, Y, Y, N, N, N, N, 32'h0000_0044, 32'h0BAD_F00D, 32'h1111_1111, 5'd12, 1, N, 4'hF,   32'h0BAD_F00D, Y,   N, 32'h0,         N};
    vecs[12] = '{"sw_mis_42", Y, N, N, N, N, N, N, 32'h0000_0042, 32'h5555_5555, 32'h0,         5'd0,  1, Y, 4'h0,   32'h0,         N,   N, 32'h0,         Y};
    vecs[13] = '{"nonmem_hlt", N, N, N, N, N, N, Y, 32'hFFFF_FFFF, 32'h0,        32'h0,         5'd31, 0, N, 4'h0,   32'h0,         N,   N, 32'hFFFF_FFFF, Y};

    drive_nop();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    reset     = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Stray ack while idle must not start or disturb anything.
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("idle_ack_req", 32'(mem_req), 32'd0);
    chk("idle_ack_mis", 32'(misaligned), 32'd0);
    chk("idle_ack_stall", 32'(stall), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Reset during BUSY abandons the transaction; a late ack is ignored.
    memtoReg = 1'b1; regWrite = 1'b1; ALUresult = 32'h80; rd = 5'd2;
    tick();
    chk("rst_busy_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    drive_nop();
    tick();
    reset = 1'b0;
    check_all_zero("rst_busy");
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check_all_zero("rst_late_ack");

    // Bus wait with no ack: timeout when enabled, indefinite wait otherwise.
    memtoReg = 1'b1; regWrite = 1'b1; ALUresult = 32'h300; rd = 5'd13;
    tick();
    chk("wait_req", 32'(mem_req), 32'd1);
`ifdef MEM_TIMEOUT_EN
    e = '{"timeout", 1'b0, 5'd13, 32'h0, 1'b0, 1'b1};
    sb_q.push_back(e);
    busy = 0;
    while (stall && busy < 20) begin
      busy++;
      tick();
    end
    chk("timeout_busy_cycles", 32'(busy), 32'd4);
    chk("timeout_mis", 32'(misaligned), 32'd1);
    chk("timeout_req", 32'(mem_req), 32'd0);
    drive_nop();
    tick();
    chk("timeout_mis_end", 32'(misaligned), 32'd0);
    chk("timeout_idle_stall", 32'(stall), 32'd0);
    check_wb();
`else
    e = '{"long_wait", 1'b1, 5'd13, 32'hCAFE_F00D, 1'b0, 1'b1};
    sb_q.push_back(e);
    for (int i = 0; i < 20; i++) tick();
    chk("long_wait_stall", 32'(stall), 32'd1);
    chk("long_wait_req", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("long_wait_done_stall", 32'(stall), 32'd0);
    drive_nop();
    tick();
    check_wb();
`endif
    v = vecs[0];
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("final_rd_unchanged", 32'(v.rd), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high; ports named clock and reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, bus-wait limit (used only under REQ-030).
REQ-003 Ports (name direction width meaning):
- clock in 1 rising-edge clock
- reset in 1 sync active-high reset
- regWrite, memtoReg, memWrite in 1 each; EX/MEM control
- sb, lh, ld in 1 each; store byte, load half, load byte
- ALUresult in 32 address or non-memory result
- readData2 in 32 store data
- rd in 5 destination register
- halt in 1 halt marker
- stall out 1 holds the EX/MEM register and earlier stages
- mem_req out 1 bus request
- mem_we out 1 bus write
- mem_addr out 32 word-aligned bus address
- mem_wdata out 32 bus write data
- mem_be out 4 byte enables
- mem_ack in 1 bus completion, single-cycle pulse
- mem_rdata in 32 read data, valid with mem_ack
- wb_regWrite, wb_rd, wb_data, wb_halt out 1/5/32/1; registered MEM/WB bundle
- misaligned out 1 one-cycle error pulse

Function
REQ-004 A memory op is memWrite=1 or memtoReg=1; memWrite has priority when both are set.
REQ-005 FSM states: IDLE, BUSY, DONE.
REQ-006 IDLE with a non-memory op: at the next edge, load wb_* from the inputs (wb_data=ALUresult); stall=0; state remains IDLE.
REQ-007 IDLE with a memory op: stall=1 combinationally; latch the op at the edge. If aligned, go to BUSY with mem_req=1; if misaligned, go to DONE with misaligned=1 and no bus request.
REQ-008 BUSY: stall=1. Hold mem_req, mem_we, mem_addr, mem_wdata and mem_be stable until mem_ack. On mem_ack, capture mem_rdata, drop mem_req at the next edge and go to DONE.
REQ-009 DONE: stall=0. At the edge leaving DONE, load wb_* from the latched op and go to IDLE. The held EX/MEM entry is not re-issued.
REQ-010 mem_addr = {ALUresult[31:2],2'b00}.
REQ-011 Word store: mem_be=4'b1111, mem_wdata=readData2.
REQ-012 sb: mem_be=1<<ALUresult[1:0], mem_wdata=readData2[7:0] replicated four times.
REQ-013 Loads (mem_we=0, mem_be=4'b1111):
- word: wb_data=mem_rdata
- lh: halfword selected by addr[1], sign-extended
- ld: byte selected by addr[1:0], sign-extended
REQ-014 Stores force wb_regWrite=0.
REQ-015 Misaligned when word op has addr[1:0]!=0, or lh has addr[0]!=0. Then wb_regWrite=0, wb_data=0, and misaligned pulses for exactly one cycle.
REQ-016 Minimum memory-op latency: request to wb update is 3 edges with mem_ack in the first BUSY cycle.
REQ-017 mem_ack outside BUSY is ignored.

Reset
REQ-020 Reset returns the FSM to IDLE and clears every output to 0, including mid-BUSY; the outstanding transaction is abandoned.
REQ-021 After reset, mem_req drops at the reset edge. A late mem_ack is ignored.

Configuration
REQ-030 With MEM_TIMEOUT_EN defined, a counter runs in BUSY. At TIMEOUT_CYCLES without mem_ack: go to DONE, drop mem_req, set wb_regWrite=0 and wb_data=0, and pulse misaligned. Without the macro there is no counter and BUSY waits indefinitely.

Structure
REQ-040 The FSM state enum, the byte-enable constants and TIMEOUT default belong in the shared processor package.
REQ-041 Load alignment/sign-extension SHALL be a combinational sub-module load_extend.

Verification
REQ-050 lh at addr 0x102, mem_rdata=0x8001_1234, ack after 2 BUSY cycles -> wb_data=0xFFFF_8001, wb_regWrite=1, stall high 3 cycles.
REQ-051 sb at addr 0x203, readData2=0xAB -> mem_be=4'b1000, mem_wdata=0xABAB_ABAB, mem_we=1, wb_regWrite=0.
REQ-052 Word load at addr 0x6 -> no mem_req, misaligned pulse 1 cycle, wb_regWrite=0.
REQ-053 Non-memory op with ALUresult=0x55, rd=7 -> next edge wb_data=0x55, wb_rd=7, stall=0.
REQ-054 Reset asserted in BUSY, then mem_ack -> state IDLE, all outputs 0, ack ignored.
REQ-055 MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> after 4 BUSY cycles, misaligned pulse, mem_req=0, return to IDLE.
